pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the single-cycle RV core. It adds stall, halt/resume, trap entry and return, and redirect-target fault checking to sequential fetch and branch/jump loading. It sits at the head of the fetch path, drives the instruction-memory address, and takes redirect, trap and control inputs from the decode/execute stage and the CSR logic.

Parameters:
XLEN, 32, address/data width in bits.
RESET_VECTOR, 32'h0000_0000, PC value after reset; base of program region.
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry or target fault.
PROG_BYTES, 1024, size of program region in bytes; multiple of 4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  hold PC this cycle, RUN state only.
halt  input  1  enter HALTED.
resume  input  1  leave HALTED.
redirect_valid  input  1  load redirect_target (branch/jump taken).
redirect_target  input  XLEN  redirect destination.
trap_req  input  1  synchronous exception/interrupt request.
mret  input  1  return from trap to epc.
pc  output  XLEN  current fetch address (registered).
pc_plus4  output  XLEN  pc+4, combinational, link value for JAL/JALR.
pc_valid  output  1  pc is a valid fetch address this cycle.
epc  output  XLEN  saved exception PC (registered).
target_fault  output  1  one-cycle pulse: rejected redirect target.
halted  output  1  high while in HALTED.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-low. While reset=0: pc=RESET_VECTOR, epc=RESET_VECTOR, state=BOOT, pc_valid=0, target_fault=0, halted=0.
- FSM states (pc_state_t): BOOT, RUN, HALTED.
  - BOOT: one cycle after reset release, pc_valid=0, pc holds. Then go to RUN.
  - RUN: pc_valid=1.
  - HALTED: pc_valid=0, halted=1, pc/epc hold. trap_req, mret and redirect_valid are ignored. resume goes to RUN next cycle with pc unchanged.
- RUN next-PC priority, highest first:
  1. trap_req: epc<=pc, pc<=TRAP_VECTOR.
  2. mret: pc<=epc.
  3. redirect_valid with bad target: target_fault=1 next cycle, epc<=pc, pc<=TRAP_VECTOR.
  4. redirect_valid with good target: pc<=redirect_target.
  5. stall: pc holds.
  6. Sequential: pc<=pc+4, wrapping (see below).
- Bad target: redirect_target[1:0]!=0, or target outside [RESET_VECTOR, RESET_VECTOR+PROG_BYTES).
- halt: sampled in RUN after the next-PC update of that cycle, so the PC update completes, then go to HALTED. If trap_req and halt are both high, the trap load completes first and then the block halts.
- Latency: every update appears on pc the cycle after the inputs are sampled. pc_plus4 is combinational, zero latency.
- Wrap: if pc+4 >= RESET_VECTOR+PROG_BYTES, the sequential next PC is RESET_VECTOR. The compare is on the full sum; the adder is XLEN+1 bits to catch carry-out. Wrap applies only to sequential step, never to a redirect.
- stall is ignored in BOOT and HALTED. Redirect and trap override stall.
- mret and trap_req both high: trap wins; epc is overwritten with the current pc.
- target_fault is a single-cycle pulse only. It is cleared by reset or in the next cycle.
- Reset asserted mid-operation (any state): immediate return to reset values, no partial update.

Decomposition:
- Package pc_pkg:
  - pc_state_t enum {BOOT, RUN, HALTED}.
  - INSTR_BYTES = 4.
  - Function is_aligned(addr).
- Sub-module pc_target_check: combinational, parametrised by XLEN/RESET_VECTOR/PROG_BYTES. Input target; output bad (misaligned or out-of-range). Reused later by JALR in execute.
- All sequential logic and the priority mux stay in pc_sequencer.

Test Plan:
- Reset release, no inputs: cycle 0 pc=0, pc_valid=0; then pc=0,4,8 with pc_valid=1; pc_plus4 always pc+4.
- Run to end, PROG_BYTES=1024: pc=0x3FC, next cycle pc=0x000, no fault.
- pc=0x10, redirect_valid=1, target=0x80: next pc=0x80. Target=0x82: target_fault pulses 1 cycle, epc=0x10, pc=0x100. Target=0x400: same fault behaviour.
- pc=0x20, trap_req=1 with mret=1 and stall=1: pc=0x100, epc=0x20. Two cycles later mret=1: pc=0x20.
- pc=0x40, stall=1 for 3 cycles: pc=0x40 for 3 cycles, then 0x44. Stall with redirect to 0x8: pc=0x8.
- halt at pc=0x50: pc=0x54, halted=1, pc_valid=0; redirect ignored. resume: pc_valid=1 with pc=0x54, then 0x58. Reset pulsed while halted: pc=0, BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its target checker.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam int INSTR_BYTES = 4;

    // Word alignment only depends on the two low address bits.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/pc_target_check.sv
// Flags a control-transfer target that is misaligned or outside the program region.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of target.
// Ports: target (candidate destination address), bad (1 = reject target).
module pc_target_check
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] PROG_BYTES   = 1024
) (
    input  logic [XLEN-1:0] target,
    output logic            bad
);

    // One extra bit so base+size cannot overflow when the region ends at the top of memory.
    localparam logic [XLEN:0] PROG_BASE = {1'b0, RESET_VECTOR};
    localparam logic [XLEN:0] PROG_END  = {1'b0, RESET_VECTOR} + {1'b0, PROG_BYTES};

    logic [XLEN:0] target_ext;

    assign target_ext = {1'b0, target};

    always_comb begin
        bad = !is_aligned(target[1:0])
           || (target_ext < PROG_BASE)
           || (target_ext >= PROG_END);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with stall, halt/resume, trap entry/return and redirect target checking.
// Latency: every pc/epc update is visible one cycle after the inputs are sampled; pc_plus4 is combinational.
// Backpressure: stall holds pc in RUN only; halt parks the sequencer until resume.
// Ports: clk, reset (async active-low); controls stall/halt/resume/trap_req/mret;
//        redirect_valid/redirect_target; outputs pc, pc_plus4, pc_valid, epc, target_fault, halted.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [XLEN-1:0] PROG_BYTES   = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            mret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            target_fault,
    output logic            halted
);

    localparam logic [XLEN:0] PROG_END = {1'b0, RESET_VECTOR} + {1'b0, PROG_BYTES};
    localparam logic [XLEN:0] STEP     = (XLEN+1)'(INSTR_BYTES);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] epc_nxt;
    logic            fault_nxt;
    logic [XLEN:0]   pc_sum;
    logic            target_bad;

    pc_target_check #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR),
        .PROG_BYTES   (PROG_BYTES)
    ) u_target_check (
        .target (redirect_target),
        .bad    (target_bad)
    );

    // Carry-out is kept so a region ending at the top of the address space still wraps.
    assign pc_sum   = {1'b0, pc} + STEP;
    assign pc_plus4 = pc_sum[XLEN-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            epc          <= RESET_VECTOR;
            target_fault <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            epc          <= epc_nxt;
            target_fault <= fault_nxt;
        end
    end

    // Next-state and next-PC priority mux.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        epc_nxt   = epc;
        fault_nxt = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    epc_nxt = pc;
                    pc_nxt  = TRAP_VECTOR;
                end else if (mret) begin
                    pc_nxt = epc;
                end else if (redirect_valid && target_bad) begin
                    fault_nxt = 1'b1;
                    epc_nxt   = pc;
                    pc_nxt    = TRAP_VECTOR;
                end else if (redirect_valid) begin
                    pc_nxt = redirect_target;
                end else if (stall) begin
                    pc_nxt = pc;
                end else if (pc_sum >= PROG_END) begin
                    pc_nxt = RESET_VECTOR;
                end else begin
                    pc_nxt = pc_sum[XLEN-1:0];
                end
                // halt does not suppress this cycle's PC update; it only parks afterwards.
                if (halt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        pc_valid = (state == RUN);
        halted   = (state == HALTED);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed checks of the PC sequencer against hand-computed values.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic [31:0] epc;
    logic        target_fault;
    logic        halted;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .PROG_BYTES   (32'd1024)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .halt            (halt),
        .resume          (resume),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .mret            (mret),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .pc_valid        (pc_valid),
        .epc             (epc),
        .target_fault    (target_fault),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load pc with a known-good address through a redirect (RUN state only).
    task automatic goto(input logic [31:0] addr);
        redirect_valid  = 1'b1;
        redirect_target = addr;
        step();
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 0; halt = 0; resume = 0;
        redirect_valid = 0; redirect_target = 0; trap_req = 0; mret = 0;
        repeat (3) step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
        checks++; if ({pc_valid, halted, target_fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {pc_valid, halted, target_fault}); end
        reset = 1'b1;
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL boot_cycle pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== exp_pc || pc_valid !== 1'b1) begin errors++; $display("FAIL seq_%0d pc=%h valid=%b exp pc=%h valid=1", i, pc, pc_valid, exp_pc); end
            checks++; if (pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_plus4_%0d got=%h exp=%h", i, pc_plus4, exp_pc + 32'd4); end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_wrap();
        goto(32'h0000_03FC);
        checks++; if (pc !== 32'h3FC) begin errors++; $display("FAIL wrap_pre got=%h exp=%h", pc, 32'h3FC); end
        checks++; if (pc_plus4 !== 32'h400) begin errors++; $display("FAIL wrap_plus4 got=%h exp=%h", pc_plus4, 32'h400); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (target_fault !== 1'b0) begin errors++; $display("FAIL wrap_fault got=%b exp=0", target_fault); end
    endtask

    task automatic test_redirect();
        goto(32'h10);
        redirect_valid = 1; redirect_target = 32'h80;
        step();
        redirect_valid = 0;
        checks++; if (pc !== 32'h80 || target_fault !== 1'b0) begin errors++; $display("FAIL redir_good pc=%h fault=%b exp pc=80 fault=0", pc, target_fault); end
        goto(32'h10);
        redirect_valid = 1; redirect_target = 32'h82;
        step();
        redirect_valid = 0;
        checks++; if (pc !== 32'h100 || epc !== 32'h10) begin errors++; $display("FAIL redir_misalign pc=%h epc=%h exp pc=100 epc=10", pc, epc); end
        checks++; if (target_fault !== 1'b1) begin errors++; $display("FAIL redir_misalign_fault got=%b exp=1", target_fault); end
        step();
        checks++; if (target_fault !== 1'b0 || pc !== 32'h104) begin errors++; $display("FAIL redir_fault_pulse fault=%b pc=%h exp fault=0 pc=104", target_fault, pc); end
        goto(32'h10);
        redirect_valid = 1; redirect_target = 32'h400;
        step();
        redirect_valid = 0;
        checks++; if (pc !== 32'h100 || epc !== 32'h10 || target_fault !== 1'b1) begin errors++; $display("FAIL redir_range pc=%h epc=%h fault=%b exp pc=100 epc=10 fault=1", pc, epc, target_fault); end
        step();
        checks++; if (target_fault !== 1'b0) begin errors++; $display("FAIL redir_range_pulse got=%b exp=0", target_fault); end
    endtask

    task automatic test_trap();
        goto(32'h20);
        trap_req = 1; mret = 1; stall = 1;
        step();
        trap_req = 0; mret = 0; stall = 0;
        checks++; if (pc !== 32'h100 || epc !== 32'h20) begin errors++; $display("FAIL trap_entry pc=%h epc=%h exp pc=100 epc=20", pc, epc); end
        step();
        step();
        checks++; if (pc !== 32'h108) begin errors++; $display("FAIL trap_handler got=%h exp=%h", pc, 32'h108); end
        mret = 1;
        step();
        mret = 0;
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL mret_return got=%h exp=%h", pc, 32'h20); end
    endtask

    task automatic test_stall();
        goto(32'h40);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, pc, 32'h40); end
            if (i < 2) step();
        end
        stall = 0;
        step();
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL stall_release got=%h exp=%h", pc, 32'h44); end
        stall = 1; redirect_valid = 1; redirect_target = 32'h8;
        step();
        stall = 0; redirect_valid = 0;
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_redirect got=%h exp=%h", pc, 32'h8); end
    endtask

    task automatic test_trap_halt();
        goto(32'h60);
        trap_req = 1; halt = 1;
        step();
        trap_req = 0; halt = 0;
        checks++; if (pc !== 32'h100 || epc !== 32'h60 || halted !== 1'b1) begin errors++; $display("FAIL trap_halt pc=%h epc=%h halted=%b exp pc=100 epc=60 halted=1", pc, epc, halted); end
        step();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_halt_hold got=%h exp=%h", pc, 32'h100); end
        resume = 1;
        step();
        resume = 0;
        checks++; if (pc !== 32'h100 || pc_valid !== 1'b1) begin errors++; $display("FAIL trap_halt_resume pc=%h valid=%b exp pc=100 valid=1", pc, pc_valid); end
    endtask

    task automatic test_halt();
        goto(32'h50);
        halt = 1;
        step();
        halt = 0;
        checks++; if (pc !== 32'h54 || halted !== 1'b1 || pc_valid !== 1'b0) begin errors++; $display("FAIL halt_enter pc=%h halted=%b valid=%b exp pc=54 halted=1 valid=0", pc, halted, pc_valid); end
        redirect_valid = 1; redirect_target = 32'h80; trap_req = 1; stall = 1;
        step();
        redirect_valid = 0; trap_req = 0; stall = 0;
        checks++; if (pc !== 32'h54 || epc !== 32'h60 || target_fault !== 1'b0) begin errors++; $display("FAIL halt_ignore pc=%h epc=%h fault=%b exp pc=54 epc=60 fault=0", pc, epc, target_fault); end
        resume = 1;
        step();
        resume = 0;
        checks++; if (pc !== 32'h54 || pc_valid !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_resume pc=%h valid=%b halted=%b exp pc=54 valid=1 halted=0", pc, pc_valid, halted); end
        step();
        checks++; if (pc !== 32'h58) begin errors++; $display("FAIL halt_resume_seq got=%h exp=%h", pc, 32'h58); end
        halt = 1;
        step();
        halt = 0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pc !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0 || epc !== 32'h0) begin errors++; $display("FAIL halt_reset pc=%h halted=%b valid=%b epc=%h exp all zero", pc, halted, pc_valid, epc); end
        step();
        reset = 1'b1;
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL halt_reset_boot pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid); end
        step();
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL halt_reset_run pc=%h valid=%b exp pc=0 valid=1", pc, pc_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_redirect();
        test_trap();
        test_stall();
        test_trap_halt();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
